// File: rtl/ps_mul_pkg.sv
// Shared constants and types for the multiplier-issue slice.
// Instruction class/slice encodings, dtsts bit positions, FSM states, E-stage record.
package ps_mul_pkg;

    localparam logic [1:0] CLS_SAT = 2'b00;
    localparam logic [1:0] CLS_PRD = 2'b01;
    localparam logic [1:0] CLS_ACC = 2'b10;
    localparam logic [1:0] CLS_SUB = 2'b11;

    localparam logic [1:0] SC_MR0 = 2'b00;
    localparam logic [1:0] SC_MR1 = 2'b01;
    localparam logic [1:0] SC_MR2 = 2'b10;
    localparam logic [1:0] SC_SAT = 2'b11;

    localparam int DT_RND   = 0;
    localparam int DT_IBF   = 1;
    localparam int DT_RXUBS = 2;
    localparam int DT_RYUBS = 3;

    localparam int E_RN_W = 4;

    typedef enum logic {
        ISSUE = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [E_RN_W-1:0] rn;
        logic              wr_rn;
        logic              upd_flags;
    } e_stage_t;

endpackage

// File: rtl/ps_mul_decode.sv
// Purely combinational: derives register-file usage and flag-update intent
// from the instruction class, MR slice select and destination select.
module ps_mul_decode
    import ps_mul_pkg::*;
(
    input  logic [1:0] i_cls,
    input  logic [1:0] i_sc,
    input  logic       i_otreg,
    output logic       o_rd_x,
    output logic       o_rd_y,
    output logic       o_wr_rn,
    output logic       o_upd_flags
);

    logic w_is_sat_cls;
    logic w_is_sat_op;

    assign w_is_sat_cls = (i_cls == CLS_SAT);
    assign w_is_sat_op  = w_is_sat_cls & (i_sc == SC_SAT);

    // Rx is read by every multiply, and by MR-slice writes from a register.
    assign o_rd_x      = ~w_is_sat_cls | (i_otreg & (i_sc != SC_SAT));
    assign o_rd_y      = ~w_is_sat_cls;
    assign o_wr_rn     = ~i_otreg & ~w_is_sat_op;
    assign o_upd_flags = ~w_is_sat_cls | (i_sc == SC_SAT);

endmodule

// File: rtl/ps_mul_issue.sv
// Multiplier issuer: decode-cycle control, one-cycle-later Rn writeback and ASTAT update.
// Optional sticky ASTAT flags under macro PS_MUL_STICKY_EN.
module ps_mul_issue
    import ps_mul_pkg::*;
#(
    parameter int RF_DATASIZE = 16,
    parameter int RF_ADDRSIZE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ps_instr_vld,
    output logic                   ps_instr_rdy,
    input  logic [1:0]             ps_instr_cls,
    input  logic [1:0]             ps_instr_sc,
    input  logic [3:0]             ps_instr_dtsts,
    input  logic                   ps_instr_otreg,
    input  logic [RF_ADDRSIZE-1:0] ps_instr_rn,
    input  logic [RF_ADDRSIZE-1:0] ps_instr_rx,
    input  logic [RF_ADDRSIZE-1:0] ps_instr_ry,
    input  logic                   ps_stall,
    output logic                   ps_mul_en,
    output logic                   ps_mul_otreg,
    output logic [3:0]             ps_mul_dtsts,
    output logic [1:0]             ps_mul_cls,
    output logic [1:0]             ps_mul_sc,
    output logic [RF_ADDRSIZE-1:0] ps_rf_rxa,
    output logic [RF_ADDRSIZE-1:0] ps_rf_rya,
    input  logic [RF_DATASIZE-1:0] mul_xb_dt,
    input  logic                   mul_ps_mv,
    input  logic                   mul_ps_mn,
    output logic                   rf_wen,
    output logic [RF_ADDRSIZE-1:0] rf_wa,
    output logic [RF_DATASIZE-1:0] rf_wd,
    output logic                   astat_mv,
    output logic                   astat_mn
`ifdef PS_MUL_STICKY_EN
    ,
    input  logic                   astat_clr,
    output logic                   astat_mvs,
    output logic                   astat_mns
`endif
);

    state_t   r_state;
    state_t   w_state_nxt;
    e_stage_t r_e;
    e_stage_t w_e_nxt;

    logic w_rd_x;
    logic w_rd_y;
    logic w_wr_rn;
    logic w_upd_flags;
    logic w_hazard;
    logic w_rdy;
    logic w_issue;
    logic w_e_wen;
    logic w_e_upd;

    ps_mul_decode u_decode (
        .i_cls       (ps_instr_cls),
        .i_sc        (ps_instr_sc),
        .i_otreg     (ps_instr_otreg),
        .o_rd_x      (w_rd_x),
        .o_rd_y      (w_rd_y),
        .o_wr_rn     (w_wr_rn),
        .o_upd_flags (w_upd_flags)
    );

    // Only Rn-writing ops in E can feed a dependent reader; self-reference is harmless.
    assign w_hazard = r_e.vld & r_e.wr_rn &
                      ((w_rd_x & (ps_instr_rx == RF_ADDRSIZE'(r_e.rn))) |
                       (w_rd_y & (ps_instr_ry == RF_ADDRSIZE'(r_e.rn))));

    always_comb begin
        w_state_nxt = ISSUE;
        w_rdy       = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ISSUE: begin
                w_rdy   = ~ps_stall & ~w_hazard;
                w_issue = ps_instr_vld & w_rdy;
                if (ps_instr_vld & w_hazard & ~ps_stall) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_state_nxt = ISSUE;
            end
            default: w_state_nxt = ISSUE;
        endcase
        if (reset) begin
            w_rdy   = 1'b0;
            w_issue = 1'b0;
        end
    end

    always_comb begin
        w_e_nxt           = '0;
        w_e_nxt.vld       = w_issue;
        w_e_nxt.rn        = E_RN_W'(ps_instr_rn);
        w_e_nxt.wr_rn     = w_wr_rn;
        w_e_nxt.upd_flags = w_upd_flags;
    end

    assign ps_instr_rdy = w_rdy;
    assign ps_mul_en    = w_issue;
    assign ps_mul_otreg = w_issue & ps_instr_otreg;
    assign ps_mul_dtsts = w_issue ? ps_instr_dtsts : 4'd0;
    assign ps_mul_cls   = w_issue ? ps_instr_cls : 2'd0;
    assign ps_mul_sc    = w_issue ? ps_instr_sc : 2'd0;
    assign ps_rf_rxa    = w_issue ? ps_instr_rx : '0;
    assign ps_rf_rya    = w_issue ? ps_instr_ry : '0;

    assign w_e_wen = ~reset & r_e.vld & r_e.wr_rn;
    assign w_e_upd = r_e.vld & r_e.upd_flags;
    assign rf_wen  = w_e_wen;
    assign rf_wa   = w_e_wen ? RF_ADDRSIZE'(r_e.rn) : '0;
    assign rf_wd   = w_e_wen ? mul_xb_dt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ISSUE;
            r_e      <= '0;
            astat_mv <= 1'b0;
            astat_mn <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_e     <= w_e_nxt;
            if (w_e_upd) begin
                astat_mv <= mul_ps_mv;
                astat_mn <= mul_ps_mn;
            end
        end
    end

`ifdef PS_MUL_STICKY_EN
    // A clear coincident with an update keeps the fresh update.
    always_ff @(posedge clk) begin
        if (reset) begin
            astat_mvs <= 1'b0;
            astat_mns <= 1'b0;
        end else if (astat_clr) begin
            astat_mvs <= w_e_upd & mul_ps_mv;
            astat_mns <= w_e_upd & mul_ps_mn;
        end else begin
            astat_mvs <= astat_mvs | (w_e_upd & mul_ps_mv);
            astat_mns <= astat_mns | (w_e_upd & mul_ps_mn);
        end
    end
`endif

endmodule

// File: tb/tb_ps_mul_issue.sv
// Randomized and directed bench for ps_mul_issue against a transaction-level model.
module tb_ps_mul_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_instr_vld;
    logic        ps_instr_rdy;
    logic [1:0]  ps_instr_cls;
    logic [1:0]  ps_instr_sc;
    logic [3:0]  ps_instr_dtsts;
    logic        ps_instr_otreg;
    logic [3:0]  ps_instr_rn;
    logic [3:0]  ps_instr_rx;
    logic [3:0]  ps_instr_ry;
    logic        ps_stall;
    logic        ps_mul_en;
    logic        ps_mul_otreg;
    logic [3:0]  ps_mul_dtsts;
    logic [1:0]  ps_mul_cls;
    logic [1:0]  ps_mul_sc;
    logic [3:0]  ps_rf_rxa;
    logic [3:0]  ps_rf_rya;
    logic [15:0] mul_xb_dt;
    logic        mul_ps_mv;
    logic        mul_ps_mn;
    logic        rf_wen;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        astat_mv;
    logic        astat_mn;
    logic        astat_clr;
    logic        astat_mvs;
    logic        astat_mns;

    ps_mul_issue #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps_instr_vld   (ps_instr_vld),
        .ps_instr_rdy   (ps_instr_rdy),
        .ps_instr_cls   (ps_instr_cls),
        .ps_instr_sc    (ps_instr_sc),
        .ps_instr_dtsts (ps_instr_dtsts),
        .ps_instr_otreg (ps_instr_otreg),
        .ps_instr_rn    (ps_instr_rn),
        .ps_instr_rx    (ps_instr_rx),
        .ps_instr_ry    (ps_instr_ry),
        .ps_stall       (ps_stall),
        .ps_mul_en      (ps_mul_en),
        .ps_mul_otreg   (ps_mul_otreg),
        .ps_mul_dtsts   (ps_mul_dtsts),
        .ps_mul_cls     (ps_mul_cls),
        .ps_mul_sc      (ps_mul_sc),
        .ps_rf_rxa      (ps_rf_rxa),
        .ps_rf_rya      (ps_rf_rya),
        .mul_xb_dt      (mul_xb_dt),
        .mul_ps_mv      (mul_ps_mv),
        .mul_ps_mn      (mul_ps_mn),
        .rf_wen         (rf_wen),
        .rf_wa          (rf_wa),
        .rf_wd          (rf_wd),
        .astat_mv       (astat_mv),
        .astat_mn       (astat_mn)
`ifdef PS_MUL_STICKY_EN
        ,
        .astat_clr      (astat_clr),
        .astat_mvs      (astat_mvs),
        .astat_mns      (astat_mns)
`endif
    );

`ifndef PS_MUL_STICKY_EN
    assign astat_mvs = 1'b0;
    assign astat_mns = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: at most one op in flight, plus a one-cycle bubble owed after a hazard.
    typedef struct {
        logic [3:0] rn;
        bit         wr;
        bit         upd;
    } op_t;

    op_t inflight[$];
    bit  owe_bubble;
    bit  m_mv, m_mn, m_mvs, m_mns;

    logic        obs_rdy, obs_en, obs_wen, obs_mv, obs_mvs;
    logic [3:0]  obs_wa;
    logic [15:0] obs_wd;

    task automatic model_clear();
        inflight.delete();
        owe_bubble = 0;
        m_mv = 0; m_mn = 0; m_mvs = 0; m_mns = 0;
    endtask

    task automatic step(input bit vld, input logic [1:0] cls, input logic [1:0] sc,
                        input logic [3:0] dtsts, input bit otreg,
                        input logic [3:0] rn, input logic [3:0] rx, input logic [3:0] ry,
                        input bit stall, input logic [15:0] dt, input bit mv, input bit mn,
                        input bit clr);
        bit rdx, rdy, wr, upd, haz, exp_rdy, issue, e_wr, e_upd;
        @(negedge clk);
        ps_instr_vld = vld; ps_instr_cls = cls; ps_instr_sc = sc; ps_instr_dtsts = dtsts;
        ps_instr_otreg = otreg; ps_instr_rn = rn; ps_instr_rx = rx; ps_instr_ry = ry;
        ps_stall = stall; mul_xb_dt = dt; mul_ps_mv = mv; mul_ps_mn = mn; astat_clr = clr;
        #2;
        rdx = (cls != 2'b00) || (otreg && sc != 2'b11);
        rdy = (cls != 2'b00);
        wr  = !otreg && !(cls == 2'b00 && sc == 2'b11);
        upd = (cls != 2'b00) || (sc == 2'b11);
        haz = inflight.size() != 0 && inflight[0].wr &&
              ((rdx && rx == inflight[0].rn) || (rdy && ry == inflight[0].rn));
        exp_rdy = !stall && !owe_bubble && !haz;
        issue = vld && exp_rdy;
        e_wr  = inflight.size() != 0 && inflight[0].wr;
        e_upd = inflight.size() != 0 && inflight[0].upd;

        obs_rdy = ps_instr_rdy; obs_en = ps_mul_en; obs_wen = rf_wen;
        obs_wa = rf_wa; obs_wd = rf_wd; obs_mv = astat_mv; obs_mvs = astat_mvs;

        check("rdy", ps_instr_rdy, exp_rdy);
        check("mul_en", ps_mul_en, issue);
        if (issue) begin
            check("rxa", ps_rf_rxa, rx);
            check("rya", ps_rf_rya, ry);
            check("mul_cls", ps_mul_cls, cls);
            check("mul_sc", ps_mul_sc, sc);
            check("mul_dtsts", ps_mul_dtsts, dtsts);
            check("mul_otreg", ps_mul_otreg, otreg);
        end
        check("rf_wen", rf_wen, e_wr);
        if (e_wr) begin
            check("rf_wa", rf_wa, inflight[0].rn);
            check("rf_wd", rf_wd, dt);
        end
        check("astat_mv", astat_mv, m_mv);
        check("astat_mn", astat_mn, m_mn);
`ifdef PS_MUL_STICKY_EN
        check("astat_mvs", astat_mvs, m_mvs);
        check("astat_mns", astat_mns, m_mns);
`endif
        @(posedge clk);
        if (e_upd) begin
            m_mv = mv;
            m_mn = mn;
        end
        if (clr) begin
            m_mvs = e_upd && mv;
            m_mns = e_upd && mn;
        end else begin
            m_mvs = m_mvs || (e_upd && mv);
            m_mns = m_mns || (e_upd && mn);
        end
        owe_bubble = vld && haz && !stall && !owe_bubble;
        inflight.delete();
        if (issue) inflight.push_back('{rn: rn, wr: wr, upd: upd});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ps_instr_vld = 1'b1; ps_stall = 1'b0; astat_clr = 1'b0;
        #2;
        check("rst_rdy", ps_instr_rdy, 0);
        check("rst_en", ps_mul_en, 0);
        check("rst_wen", rf_wen, 0);
        @(negedge clk);
        #2;
        check("rst_astat", {astat_mv, astat_mn, astat_mvs, astat_mns}, 0);
        check("rst_wen2", rf_wen, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic idle(input logic [15:0] dt, input bit mv, input bit mn);
        step(0, 2'b01, 2'b00, 4'h0, 0, 4'hF, 4'hE, 4'hD, 0, dt, mv, mn, 0);
    endtask

    initial begin
        reset = 1'b1;
        ps_instr_vld = 0; ps_instr_cls = 0; ps_instr_sc = 0; ps_instr_dtsts = 0;
        ps_instr_otreg = 0; ps_instr_rn = 0; ps_instr_rx = 0; ps_instr_ry = 0;
        ps_stall = 0; mul_xb_dt = 0; mul_ps_mv = 0; mul_ps_mn = 0; astat_clr = 0;
        model_clear();
        do_reset();

        // Product R2=R0*R1, then dependent R3=R2*R4 costs one bubble.
        step(1, 2'b01, 2'b00, 4'b1100, 0, 4'd2, 4'd0, 4'd1, 0, 16'h0, 0, 0, 0);
        check("tp1_en", obs_en, 1);
        step(1, 2'b01, 2'b00, 4'b0000, 0, 4'd3, 4'd2, 4'd4, 0, 16'h1234, 1, 0, 0);
        check("tp1_wen", obs_wen, 1);
        check("tp1_wa", obs_wa, 2);
        check("tp1_wd", obs_wd, 16'h1234);
        check("tp2_haz_rdy", obs_rdy, 0);
        step(1, 2'b01, 2'b00, 4'b0000, 0, 4'd3, 4'd2, 4'd4, 0, 16'h0, 0, 0, 0);
        check("tp2_hold_rdy", obs_rdy, 0);
        check("tp2_hold_en", obs_en, 0);
        check("tp1_astat_mv", obs_mv, 1);
        step(1, 2'b01, 2'b00, 4'b0000, 0, 4'd3, 4'd2, 4'd4, 0, 16'h0, 0, 0, 0);
        check("tp2_issue3", obs_en, 1);
        idle(16'hBEEF, 0, 0);
        check("tp2_wa", obs_wa, 3);

        // MR0=R5 then R5=R6*R7: no hazard, no Rn write, flags untouched by first op.
        step(1, 2'b00, 2'b00, 4'h0, 1, 4'd9, 4'd5, 4'd0, 0, 16'h0, 0, 0, 0);
        check("tp3_en1", obs_en, 1);
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd5, 4'd6, 4'd7, 0, 16'h0, 1, 1, 0);
        check("tp3_en2", obs_en, 1);
        check("tp3_wen", obs_wen, 0);
        idle(16'h5555, 0, 0);
        check("tp3_astat", obs_mv, 0);
        check("tp3_wa", obs_wa, 5);

        // SAT MR: no Rn write but flags update.
        step(1, 2'b00, 2'b11, 4'h0, 1, 4'd5, 4'd0, 4'd0, 0, 16'h0, 0, 0, 0);
        idle(16'h7777, 1, 0);
        check("tp4_wen", obs_wen, 0);
        idle(16'h0, 0, 0);
        check("tp4_mv", obs_mv, 1);

        // Three stalled cycles, issue on release, then reset while the op is in E.
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b10, 2'b00, 4'h3, 0, 4'd8, 4'd1, 4'd2, 1, 16'h0, 0, 0, 0);
            check("tp5_stall_en", obs_en, 0);
            check("tp5_stall_rdy", obs_rdy, 0);
        end
        step(1, 2'b10, 2'b00, 4'h3, 0, 4'd8, 4'd1, 4'd2, 0, 16'h0, 0, 0, 0);
        check("tp5_release", obs_en, 1);
        do_reset();
        idle(16'h0, 0, 0);
        check("tp5_post_rst_wen", obs_wen, 0);

        // Self-referencing rn==rx following a writer of a different register.
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd6, 4'd6, 4'd6, 0, 16'h0, 0, 0, 0);
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd7, 4'd7, 4'd1, 0, 16'h0, 0, 0, 0);
        check("self_ref_en", obs_en, 1);
        idle(16'h0, 0, 0);

`ifdef PS_MUL_STICKY_EN
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd1, 4'd2, 4'd3, 0, 16'h0, 0, 0, 0);
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd4, 4'd2, 4'd3, 0, 16'h0, 1, 0, 0);
        idle(16'h0, 0, 0);
        check("sticky_set", obs_mvs, 1);
        idle(16'h0, 0, 0);
        check("sticky_hold", obs_mvs, 1);
        idle(16'h0, 0, 1);
        idle(16'h0, 0, 0);
        check("sticky_clr", obs_mvs, 0);
        step(1, 2'b01, 2'b00, 4'h0, 0, 4'd1, 4'd2, 4'd3, 0, 16'h0, 0, 0, 0);
        step(0, 2'b01, 2'b00, 4'h0, 0, 4'd1, 4'd2, 4'd3, 0, 16'h0, 1, 0, 1);
        idle(16'h0, 0, 0);
        check("sticky_clr_upd", obs_mvs, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom), 4'($urandom),
                 1'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, 16'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
